fp_normalizer: RTL and testbench

- Post-add normalisation stage. Sits directly downstream of the mantissa adder datapath.
- Consumes the signed two's-complement mantissa sum and the larger operand exponent, then converts them into a sign/magnitude IEEE-754 single-precision word.
- Normalises iteratively: one bit shift per cycle, under a small FSM with start/done handshake.
- Replaces the adder datapath's single-bit-overflow exponent fix-up with full left/right normalisation plus zero, overflow and underflow handling.

---
 rtl/fp_norm_pkg.sv | 17 +
 rtl/fp_normalizer_abs_sum.sv | 15 +
 rtl/fp_normalizer.sv | 108 ++++++++++
 tb/tb_fp_normalizer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared constants and FSM encoding for the post-add float normaliser.
package fp_norm_pkg;

  localparam int DEF_SUM_W  = 26;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MAN_W  = 23;

  localparam int HIDDEN_BIT = 23;
  localparam int CARRY_BIT  = 24;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/fp_normalizer_abs_sum.sv
// Combinational two's-complement absolute value; drops the sign bit of the result.
module abs_sum #(
  parameter int SUM_W = 26
) (
  input  logic signed [SUM_W-1:0] sumIn,
  output logic        [SUM_W-2:0] mag
);

  logic signed [SUM_W-1:0] negSum;

  // Callers keep |sumIn| below 2^(SUM_W-1), so the negation never needs the top bit.
  assign negSum = -sumIn;
  assign mag    = sumIn[SUM_W-1] ? negSum[SUM_W-2:0] : sumIn[SUM_W-2:0];

endmodule

// File: rtl/fp_normalizer.sv
// Iterative one-bit-per-cycle normaliser turning a signed mantissa sum plus
// exponent into an IEEE-754 single word, with zero/overflow/underflow flags.
module fp_normalizer
  import fp_norm_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [SUM_W-1:0] sum_in,
  input  logic        [EXP_W-1:0] exp_in,
  output logic                    busy,
  output logic                    done,
  output logic        [31:0]      float_out,
  output logic                    zero,
  output logic                    ovf,
  output logic                    unf
);

  logic [1:0]       state;
  logic [SUM_W-2:0] magReg;
  logic [EXP_W:0]   expReg;
  logic [EXP_W:0]   expInc;
  logic             signReg;
  logic [SUM_W-2:0] absMag;

  function automatic logic [31:0] zeroWord(input logic s);
    return {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [31:0] infWord(input logic s);
    return {s, EXP_MAX, {MAN_W{1'b0}}};
  endfunction

  abs_sum #(.SUM_W(SUM_W)) uAbs (
    .sumIn (sum_in),
    .mag   (absMag)
  );

  // Nine-bit exponent so the carry increment cannot wrap past 255.
  assign expInc = expReg + {{EXP_W{1'b0}}, 1'b1};
  assign busy   = (state == NORM);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      magReg    <= '0;
      expReg    <= '0;
      signReg   <= 1'b0;
      float_out <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            signReg   <= sum_in[SUM_W-1];
            magReg    <= absMag;
            expReg    <= {1'b0, exp_in};
            float_out <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            state     <= NORM;
          end
        end
        // One rule per cycle, priority order matters.
        NORM: begin
          if (magReg == '0) begin
            float_out <= zeroWord(signReg);
            zero      <= 1'b1;
            state     <= DONE;
          end else if (expReg == {1'b0, EXP_MAX}) begin
            float_out <= infWord(signReg);
            ovf       <= 1'b1;
            state     <= DONE;
          end else if (magReg[CARRY_BIT]) begin
            magReg <= magReg >> 1;
            expReg <= expInc;
            if (expInc == {1'b0, EXP_MAX}) begin
              float_out <= infWord(signReg);
              ovf       <= 1'b1;
              state     <= DONE;
            end
          end else if (magReg[HIDDEN_BIT]) begin
            float_out <= {signReg, expReg[EXP_W-1:0], magReg[MAN_W-1:0]};
            state     <= DONE;
          end else if (expReg <= {{EXP_W{1'b0}}, 1'b1}) begin
            float_out <= zeroWord(signReg);
            unf       <= 1'b1;
            state     <= DONE;
          end else begin
            magReg <= magReg << 1;
            expReg <= expReg - {{EXP_W{1'b0}}, 1'b1};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed and randomized checks of fp_normalizer against an arithmetic reference.
module tb_fp_normalizer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [25:0] sum_in;
  logic        [7:0]  exp_in;
  logic               busy, done, zero, ovf, unf;
  logic        [31:0] float_out;

  int checks = 0;
  int passes = 0;

  fp_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum_in    (sum_in),
    .exp_in    (exp_in),
    .busy      (busy),
    .done      (done),
    .float_out (float_out),
    .zero      (zero),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: value-level reasoning about the leading one and exponent budget.
  task automatic model(input logic [25:0] s, input logic [7:0] e,
                       output logic [31:0] f, output logic [2:0] flags, output int lat);
    logic        sgn;
    int          v, m, p, k, ei;
    logic [31:0] shifted;
    sgn   = s[25];
    v     = int'($signed(s));
    m     = (v < 0) ? -v : v;
    ei    = int'(e);
    flags = 3'b000;
    f     = {sgn, 31'b0};
    lat   = 2;
    if (m == 0) begin
      flags = 3'b100;
    end else if (ei == 255) begin
      flags = 3'b010;
      f     = {sgn, 8'hFF, 23'b0};
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if ((m >> i) != 0) p = i;
      if (p == 24) begin
        if (ei + 1 == 255) begin
          flags = 3'b010;
          f     = {sgn, 8'hFF, 23'b0};
        end else begin
          shifted = 32'(m >> 1);
          f   = {sgn, 8'(ei + 1), shifted[22:0]};
          lat = 3;
        end
      end else begin
        k = 23 - p;
        if (k == 0 || ei - k >= 1) begin
          shifted = 32'(m) << k;
          f   = {sgn, 8'(ei - k), shifted[22:0]};
          lat = 2 + k;
        end else begin
          flags = 3'b001;
          lat   = 2 + ((ei > 1) ? ei - 1 : 0);
        end
      end
    end
  endtask

  task automatic run(input string tag, input logic [25:0] s, input logic [7:0] e, input bit poke);
    logic [31:0] ef;
    logic [2:0]  eflags;
    int          elat, c;
    model(s, e, ef, eflags, elat);
    @(negedge clk);
    sum_in = s;
    exp_in = e;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_clr"}, float_out | 32'({zero, ovf, unf}), 32'd0);
    c = 1;
    while (!done && c < 40) begin
      start = (poke && c >= 2 && c <= 4);
      sum_in = 26'(($urandom & 32'h00FFFFFF) | 32'h1);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(c), 32'(elat));
    chk({tag, "_float"}, float_out, ef);
    chk({tag, "_flags"}, 32'({zero, ovf, unf}), 32'(eflags));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, float_out, ef);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk({tag, "_no_extra"}, 32'({busy, done}), 32'd0);
      end
    end
  endtask

  initial begin
    logic [25:0] rs;
    logic [7:0]  re;
    int          w, magv;
    rst    = 1'b0;
    start  = 1'b0;
    sum_in = '0;
    exp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", float_out | 32'({busy, done, zero, ovf, unf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("norm",     26'h0800000, 8'h80, 1'b0);
    run("neg",      26'h3800000, 8'h7F, 1'b0);
    run("carry",    26'h1000000, 8'h80, 1'b0);
    run("carryovf", 26'h1000000, 8'hFE, 1'b0);
    run("lshift23", 26'h0000001, 8'h80, 1'b1);
    run("unf",      26'h0400000, 8'h01, 1'b0);
    run("zero",     26'h0000000, 8'h90, 1'b0);
    run("expmax",   26'h0800000, 8'hFF, 1'b0);
    run("negzero",  26'h3FFFFFF, 8'h00, 1'b0);

    // Abort a long normalisation mid-flight with an asynchronous reset.
    @(negedge clk);
    sum_in = 26'h0000001;
    exp_in = 8'h80;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_now", float_out | 32'({busy, done, zero, ovf, unf}), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_hold", 32'({busy, done}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run("after_rst", 26'h0000001, 8'h80, 1'b0);

    for (int n = 0; n < 40; n++) begin
      w    = $urandom_range(0, 25);
      magv = (w == 0) ? 0 : int'($urandom & ((32'h1 << w) - 1));
      rs   = $urandom_range(0, 1) ? 26'(-magv) : 26'(magv);
      case ($urandom_range(0, 7))
        0:       re = 8'h00;
        1:       re = 8'h01;
        2:       re = 8'h02;
        3:       re = 8'hFE;
        4:       re = 8'hFF;
        default: re = 8'($urandom);
      endcase
      run("rand", rs, re, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
